// File: rtl/tqv_bus_initiator.sv
// Command/response front end that runs single 8/16/32-bit transfers on the TQV peripheral bus.
// Define TQV_BUS_INIT_READMASK_EN to zero-extend read data to the transfer size.
`timescale 1ns/1ps
module tqv_bus_initiator #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [5:0]  address,
  output logic [31:0] data_in,
  output logic [1:0]  data_write_n,
  output logic [1:0]  data_read_n,
  input  logic [31:0] data_out,
  input  logic        data_ready,
  input  logic        user_interrupt,
  output logic        irq_rise
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           state, state_nxt;
  logic             write_q;
  logic [1:0]       size_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             irq_q;
  logic             accept, rd_done, rd_timeout;
  logic [31:0]      rd_data;

`ifdef TQV_BUS_INIT_READMASK_EN
  function automatic logic [31:0] mask_by_size(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'b00:   return {24'd0, d[7:0]};
      2'b01:   return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign rd_data = mask_by_size(data_out, size_q);
`else
  assign rd_data = data_out;
`endif

  assign accept  = cmd_valid && cmd_ready;
  assign rd_done = (state == BUS) && !write_q && data_ready;
  // data_ready on the final allowed cycle wins over the timeout
  assign rd_timeout = (TIMEOUT != 0) && (state == BUS) && !write_q && !data_ready &&
                      (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (cmd_size == 2'b11) ? RESP : BUS;
      BUS:     if (write_q || rd_done || rd_timeout) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready    = rst_n && (state == IDLE);
    rsp_valid    = (state == RESP);
    data_write_n = ((state == BUS) &&  write_q) ? size_q : 2'b11;
    data_read_n  = ((state == BUS) && !write_q) ? size_q : 2'b11;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q   <= 1'b0;
      size_q    <= 2'b11;
      address   <= '0;
      data_in   <= '0;
      wait_cnt  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= cmd_write;
        size_q  <= cmd_size;
        address <= cmd_addr;
        data_in <= cmd_wdata;
        if (cmd_size == 2'b11) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
      end
      if ((state == BUS) && !write_q) wait_cnt <= wait_cnt + 1'b1;
      else                            wait_cnt <= '0;
      if ((state == BUS) && write_q) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end else if (rd_done) begin
        rsp_rdata <= rd_data;
        rsp_err   <= 1'b0;
      end else if (rd_timeout) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

  // Interrupt edge detect runs regardless of bus activity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= user_interrupt;
  end

  assign irq_rise = rst_n && user_interrupt && !irq_q;

endmodule

// File: tb/tb_tqv_bus_initiator.sv
// Scoreboard bench for tqv_bus_initiator: randomized commands against a transaction-level model.
`timescale 1ns/1ps
module tb_tqv_bus_initiator;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [1:0]  cmd_size;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n, data_read_n;
  logic [31:0] data_out;
  logic        data_ready, user_interrupt, irq_rise;

  always #5 clk = ~clk;

  tqv_bus_initiator #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .address(address), .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready), .user_interrupt(user_interrupt),
    .irq_rise(irq_rise)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;    // cycles from accept to first visible rsp_valid
    int          wcyc;
    int          rcyc;
    logic [1:0]  size;
    logic [5:0]  addr;
    logic [31:0] wdata;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          cur_delay = -1;
  logic [31:0] cur_dout = '0;
  int          hold_rsp = 0;
  int          irq_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] size_data(input logic [31:0] d, input logic [1:0] sz);
`ifdef TQV_BUS_INIT_READMASK_EN
    if (sz == 2'd0) return d % 32'd256;
    if (sz == 2'd1) return d % 32'd65536;
`endif
    return d;
  endfunction

  // Transaction outcome from the command and the peripheral's response delay (-1 = never)
  function automatic exp_t model(input bit wr, input bit [1:0] sz, input bit [5:0] a,
                                 input bit [31:0] wd, input int dly, input bit [31:0] dout);
    exp_t e;
    e.size = sz; e.addr = a; e.wdata = wd; e.acc = 0;
    e.wcyc = 0; e.rcyc = 0;
    if (sz == 2'd3) begin
      e.rdata = 0; e.err = 1; e.lat = 0;
    end else if (wr) begin
      e.rdata = 0; e.err = 0; e.lat = 1; e.wcyc = 1;
    end else if (dly >= 0 && dly < TIMEOUT) begin
      e.rdata = size_data(dout, sz); e.err = 0; e.lat = dly + 1; e.rcyc = dly + 1;
    end else begin
      e.rdata = 0; e.err = 1; e.lat = TIMEOUT; e.rcyc = TIMEOUT;
    end
    return e;
  endfunction

  task automatic issue(input bit wr, input bit [1:0] sz, input bit [5:0] a,
                       input bit [31:0] wd, input int dly, input bit [31:0] dout);
    exp_t e;
    int   n;
    e = model(wr, sz, a, wd, dly, dout);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_size = sz; cmd_addr = a; cmd_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 200);
    if (!cmd_ready) begin
      check("cmd_accept", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom); cmd_size = 2'($urandom);
    cmd_addr = 6'($urandom); cmd_wdata = $urandom;
    cur_delay = dly; cur_dout = dout;
    e.acc = cyc;
    q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Peripheral: raises data_ready after cur_delay waiting cycles of a read strobe
  initial begin
    int rdc;
    rdc = 0; data_ready = 1'b0; data_out = '0;
    forever begin
      @(negedge clk);
      if (data_read_n != 2'b11) begin
        data_ready = (cur_delay >= 0 && rdc == cur_delay);
        rdc++;
      end else begin
        data_ready = 1'b0;
        rdc = 0;
      end
      data_out = data_ready ? cur_dout : $urandom;
    end
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hold_rsp > 0) begin
        rsp_ready = 1'b0;
        hold_rsp--;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: bus activity and responses compared with the head of the queue
  initial begin
    int   wc, rc;
    bit   first;
    exp_t e;
    wc = 0; rc = 0; first = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wc = 0; rc = 0; first = 1'b1;
        check("rst_write_n", 32'(data_write_n), 32'd3);
        check("rst_read_n", 32'(data_read_n), 32'd3);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      end else begin
        if (data_write_n != 2'b11 || data_read_n != 2'b11) begin
          check("one_strobe", 32'(data_write_n == 2'b11 || data_read_n == 2'b11), 32'd1);
          if (data_write_n != 2'b11) wc++;
          if (data_read_n != 2'b11) rc++;
          if (q.size() == 0) begin
            check("strobe_no_cmd", 32'({data_write_n, data_read_n}), 32'hF);
          end else begin
            e = q[0];
            check("bus_address", 32'(address), 32'(e.addr));
            if (data_write_n != 2'b11) begin
              check("write_size", 32'(data_write_n), 32'(e.size));
              check("write_data", data_in, e.wdata);
            end else begin
              check("read_size", 32'(data_read_n), 32'(e.size));
            end
          end
        end
        if (rsp_valid) begin
          if (q.size() == 0) begin
            check("rsp_no_cmd", 32'(rsp_valid), 32'd0);
          end else begin
            e = q[0];
            if (first) begin
              check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
              check("write_cycles", 32'(wc), 32'(e.wcyc));
              check("read_cycles", 32'(rc), 32'(e.rcyc));
              first = 1'b0;
            end
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            check("cmd_ready_resp", 32'(cmd_ready), 32'd0);
            check("address_hold", 32'(address), 32'(e.addr));
            check("data_in_hold", data_in, e.wdata);
            if (rsp_ready) begin
              void'(q.pop_front());
              wc = 0; rc = 0; first = 1'b1;
            end
          end
        end
        if (irq_rise) irq_seen++;
      end
    end
  end

  initial begin
    bit        wr;
    bit [1:0]  sz;
    int        dsel, d, exp_rises;
    bit        prev, b;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'b00;
    cmd_addr = '0; cmd_wdata = '0; user_interrupt = 1'b0;
    #2;
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_address", 32'(address), 32'd0);
    check("reset_data_in", data_in, 32'd0);
    check("reset_irq_rise", 32'(irq_rise), 32'd0);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'(cmd_ready), 32'd1);

    issue(1'b1, 2'd2, 6'h28, 32'h1234_5678, 0, 32'h0);
    issue(1'b0, 2'd0, 6'h00, 32'h0, 3, 32'hA5A5_A5A5);
    issue(1'b0, 2'd2, 6'h11, 32'h0, -1, 32'h0);
    issue(1'b0, 2'd1, 6'h3C, 32'h0, TIMEOUT - 1, 32'hDEAD_BEEF);
    issue(1'b0, 2'd2, 6'h3D, 32'h0, TIMEOUT, 32'h0BAD_F00D);
    drain();

    @(negedge clk);
    hold_rsp = 8;
    issue(1'b0, 2'd3, 6'h15, 32'h0000_CAFE, 0, 32'h0);
    drain();

    issue(1'b0, 2'd2, 6'h07, 32'h0, -1, 32'h0);
    repeat (3) @(posedge clk);
    #3;
    check("read_before_reset", 32'(data_read_n), 32'd2);
    rst_n = 1'b0;
    #1;
    check("async_rst_read_n", 32'(data_read_n), 32'd3);
    check("async_rst_write_n", 32'(data_write_n), 32'd3);
    check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    q.delete();
    cur_delay = -1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_midreset", 32'(cmd_ready), 32'd1);
    issue(1'b1, 2'd1, 6'h2A, 32'h0000_BEEF, 0, 32'h0);

    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      dsel = $urandom_range(0, 9);
      if (dsel < 6)       d = dsel;
      else if (dsel == 6) d = TIMEOUT - 2;
      else if (dsel == 7) d = TIMEOUT - 1;
      else if (dsel == 8) d = TIMEOUT;
      else                d = -1;
      issue(wr, sz, 6'($urandom), $urandom, d, $urandom);
    end
    drain();

    irq_seen = 0;
    @(posedge clk); #1;
    user_interrupt = 1'b1;
    repeat (10) @(posedge clk);
    #1 user_interrupt = 1'b0;
    repeat (3) @(negedge clk);
    check("irq_held_one_pulse", 32'(irq_seen), 32'd1);

    irq_seen = 0; exp_rises = 0; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      b = 1'($urandom);
      user_interrupt = b;
      if (b && !prev) exp_rises++;
      prev = b;
    end
    @(posedge clk); #1 user_interrupt = 1'b0;
    repeat (3) @(negedge clk);
    check("irq_random_rises", 32'(irq_seen), 32'(exp_rises));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tqv_bus_initiator.md
TQV_BUS_INITIATOR -- requirements
Module: tqv_bus_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: read-wait limit in clk cycles; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1, clock; rising edge active.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have cmd_valid in 1, cmd_ready out 1, cmd_write in 1, cmd_size in 2 (00=8b, 01=16b, 10=32b), cmd_addr in 6, cmd_wdata in 32: command channel.
REQ-005 SHALL have rsp_valid out 1, rsp_ready in 1, rsp_rdata out 32, rsp_err out 1: response channel.
REQ-006 SHALL have address out 6, data_in out 32, data_write_n out 2, data_read_n out 2: peripheral-bus request (11 = idle strobe).
REQ-007 SHALL have data_out in 32, data_ready in 1, user_interrupt in 1: peripheral-bus response.
REQ-008 SHALL have irq_rise out 1: one-cycle pulse on the user_interrupt rising edge.

Function
REQ-009 SHALL implement the states IDLE, BUS and RESP.
REQ-010 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on cmd_valid&&cmd_ready, and all cmd_* fields are latched.
REQ-011 SHALL, if an accepted command has cmd_size=11, skip BUS and go to RESP with rsp_err=1 and rsp_rdata=0; the strobes stay 11.
REQ-012 SHALL, on a write, spend exactly one BUS cycle with data_write_n=size, address and data_in driven, then go to RESP with rsp_err=0 and rsp_rdata=0.
REQ-013 SHALL, on a read, hold data_read_n=size from the first BUS cycle until data_ready is sampled high; data_out is captured on that edge; the next state is RESP with rsp_err=0.
REQ-014 SHALL keep data_read_n=11 and data_write_n=11 in all other cycles; at most one strobe is non-11 at any time.
REQ-015 SHALL count read BUS cycles and abort after TIMEOUT cycles without data_ready: strobe released, RESP with rsp_err=1 and rsp_rdata=0.
REQ-016 SHALL treat data_ready high in the same cycle the timeout is reached as success.
REQ-017 SHALL meet these latencies with data_ready tied to 1: accept at edge N, BUS at cycle N+1, rsp_valid=1 at cycle N+2.
REQ-018 SHALL hold rsp_valid and rsp_* stable in RESP until rsp_ready=1, then return to IDLE; a new command is accepted no earlier than the following cycle.
REQ-019 SHALL hold address and data_in at the last command's values while IDLE or RESP.
REQ-020 SHALL register user_interrupt once and assert irq_rise for one cycle when the registered value is 0 and the current value is 1; this operates independently of the FSM state.

Reset
REQ-021 SHALL clear the following on rst_n low, immediately and without waiting for clk: state=IDLE, cmd_ready=0 during reset, rsp_valid=0, rsp_err=0, rsp_rdata=0, address=0, data_in=0, strobes=11, irq_rise=0, timeout counter=0, registered irq=0.
REQ-022 SHALL abort any transaction in progress on reset mid-operation with no response; the first cycle after reset release is IDLE.

Configuration
REQ-023 SHALL, when TQV_BUS_INIT_READMASK_EN is defined, zero-extend rsp_rdata by size: 8b keeps [7:0], 16b keeps [15:0], 32b is unmasked.
REQ-024 SHALL, when TQV_BUS_INIT_READMASK_EN is undefined, return data_out unmodified in rsp_rdata.

Verification
REQ-025 SHALL cover: 32b write to addr 0x28 with wdata 0x1234_5678 -> one cycle of data_write_n=10 and address=0x28, rsp_valid two cycles after accept, rsp_err=0.
REQ-026 SHALL cover: 8b read of addr 0x00 with data_ready delayed 3 cycles and data_out=0xA5A5_A5A5 -> data_read_n=00 for 4 cycles; rsp_rdata=0x0000_00A5 with the macro and 0xA5A5_A5A5 without it.
REQ-027 SHALL cover: read with data_ready held 0 and TIMEOUT=16 -> strobe released after 16 cycles, rsp_err=1, rsp_rdata=0.
REQ-028 SHALL cover: cmd_size=11 -> no strobe activity, rsp_err=1; rsp_ready held 0 for 5 cycles -> rsp_valid and cmd_ready=0 stay stable throughout.
REQ-029 SHALL cover: rst_n pulsed low mid-read -> strobes=11 without a clk edge, no rsp_valid, next command accepted normally.
REQ-030 SHALL cover: user_interrupt 0->1 held for 10 cycles -> exactly one irq_rise pulse.
